// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fifo_arb_pkg
// Brief   : Shared state encoding and width helpers for the FIFO write arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Index width never collapses to zero, even for a single requester.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational round-robin selector; scans ptr+1, ptr+2, ... mod N.
// Revision: 1.0 - initial release
// ============================================================================
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_rr_ptr,
  output logic [NUM_REQ-1:0] o_pick,
  output logic [PTR_W-1:0]   o_idx,
  output logic               o_any
);

  int               w_sum;
  logic [PTR_W-1:0] w_cand;

  // Walk from the farthest candidate to the nearest so the nearest valid wins.
  always_comb begin
    o_pick = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    w_sum  = 0;
    w_cand = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_sum = int'(i_rr_ptr) + k;
      if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
      w_cand = PTR_W'(w_sum);
      if (i_req[w_cand]) begin
        o_idx = w_cand;
        o_any = 1'b1;
      end
    end
    o_pick[o_idx] = o_any;
  end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : fifo_wr_arbiter
// Brief   : Round-robin, burst-bounded arbiter for a shared FIFO write port.
//           Optional counters enabled by FIFO_WR_ARB_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                     w_clk,
  input  logic                     rst_w_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_last,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_w_en,
  output logic [WIDTH-1:0]         fifo_w_data,
  output logic [NUM_REQ-1:0]       grant,
`ifdef FIFO_WR_ARB_STATS_EN
  output logic [31:0]              beat_count,
  output logic [31:0]              stall_count,
`endif
  output logic                     busy
);

  localparam int               PTR_W    = ptr_width(NUM_REQ);
  localparam int               CNT_W    = cnt_width(MAX_BURST);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

  arb_state_e         r_state;
  arb_state_e         w_state_nxt;
  logic [NUM_REQ-1:0] r_grant;
  logic [PTR_W-1:0]   r_ptr;
  logic [CNT_W-1:0]   r_cnt;

  logic [NUM_REQ-1:0] w_pick;
  logic [PTR_W-1:0]   w_idx;
  logic               w_any;
  logic               w_gvalid;
  logic               w_glast;
  logic               w_beat;
  logic               w_release;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .i_req    (req_valid),
    .i_rr_ptr (r_ptr),
    .o_pick   (w_pick),
    .o_idx    (w_idx),
    .o_any    (w_any)
  );

  assign w_gvalid = |(r_grant & req_valid);
  assign w_glast  = |(r_grant & req_last);
  assign w_beat   = w_gvalid & ~fifo_full;
  assign grant    = r_grant;

  always_ff @(posedge w_clk or negedge rst_w_n) begin
    if (!rst_w_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_release   = 1'b0;
    case (r_state)
      IDLE:  if (w_any) w_state_nxt = BURST;
      BURST: begin
        // Losing valid releases at once; a full stall with valid held does not.
        if (!w_gvalid || (w_beat && (w_glast || r_cnt == LAST_CNT))) begin
          w_release   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy        = (r_state == BURST);
    req_ready   = fifo_full ? '0 : r_grant;
    fifo_w_en   = w_beat;
    fifo_w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) fifo_w_data = fifo_w_data | req_data[i*WIDTH +: WIDTH];
    end
  end

  // rr_ptr doubles as the granted index while in BURST.
  always_ff @(posedge w_clk or negedge rst_w_n) begin
    if (!rst_w_n) begin
      r_grant <= '0;
      r_ptr   <= PTR_W'(NUM_REQ - 1);
      r_cnt   <= '0;
    end else if (r_state == IDLE) begin
      if (w_any) begin
        r_grant <= w_pick;
        r_ptr   <= w_idx;
        r_cnt   <= '0;
      end
    end else begin
      if (w_beat)    r_cnt   <= r_cnt + CNT_W'(1);
      if (w_release) r_grant <= '0;
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [31:0] r_beat_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge w_clk or negedge rst_w_n) begin
    if (!rst_w_n) begin
      r_beat_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_beat && r_beat_cnt != '1) r_beat_cnt <= r_beat_cnt + 32'd1;
      if (r_state == BURST && w_gvalid && fifo_full && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign beat_count  = r_beat_cnt;
  assign stall_count = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_wr_arbiter
// Brief   : Randomized and directed checks of fifo_wr_arbiter against a
//           cycle-level behavioural model (FIFO_WR_ARB_STATS_EN optional).
// Revision: 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int MB = 4;
  localparam int VW = 2*N + W + 2;

  logic           w_clk;
  logic           rst_w_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_last;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           fifo_full;
  logic           fifo_w_en;
  logic [W-1:0]   fifo_w_data;
  logic [N-1:0]   grant;
  logic           busy;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [31:0]    beat_count;
  logic [31:0]    stall_count;
`endif

  fifo_wr_arbiter #(.WIDTH(W), .NUM_REQ(N), .MAX_BURST(MB)) dut (
    .w_clk       (w_clk),
    .rst_w_n     (rst_w_n),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .fifo_full   (fifo_full),
    .fifo_w_en   (fifo_w_en),
    .fifo_w_data (fifo_w_data),
    .grant       (grant),
`ifdef FIFO_WR_ARB_STATS_EN
    .beat_count  (beat_count),
    .stall_count (stall_count),
`endif
    .busy        (busy)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  int n_cmp;
  int n_err;

  // Model: who owns the port (-1 = nobody), last granted index, beats taken.
  int m_owner;
  int m_last;
  int m_beats;
  int m_beat_tot;
  int m_stall_tot;
  logic [VW-1:0] exp_vec;
  logic [VW-1:0] act_vec;

  assign act_vec = {grant, req_ready, fifo_w_en, fifo_w_data, busy};

  task automatic model_reset();
    m_owner     = -1;
    m_last      = N - 1;
    m_beats     = 0;
    m_beat_tot  = 0;
    m_stall_tot = 0;
  endtask

  task automatic apply(input logic [N-1:0] v, input logic [N-1:0] l, input logic f);
    logic [N-1:0] eg;
    logic [W-1:0] ed;
    logic         ew;
    @(negedge w_clk);
    req_valid = v;
    req_last  = l;
    fifo_full = f;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom);
    #1;
    eg = '0;
    ed = '0;
    ew = 1'b0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      ed = req_data[m_owner*W +: W];
      ew = v[m_owner] && !f;
    end
    exp_vec = {eg, (f ? {N{1'b0}} : eg), ew, ed, (m_owner >= 0)};
  endtask

  task automatic advance();
    if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        if (m_owner < 0 && req_valid[(m_last + k) % N]) begin
          m_owner = (m_last + k) % N;
          m_last  = m_owner;
          m_beats = 0;
        end
      end
    end else if (!req_valid[m_owner]) begin
      m_owner = -1;
    end else if (fifo_full) begin
      m_stall_tot++;
    end else begin
      m_beats++;
      m_beat_tot++;
      if (req_last[m_owner] || m_beats == MB) m_owner = -1;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      apply('0, '0, 1'b0);
      advance();
    end
  endtask

  task automatic test_reset();
    rst_w_n   = 1'b0;
    req_valid = '0;
    req_last  = '0;
    fifo_full = 1'b0;
    req_data  = '0;
    model_reset();
    repeat (2) @(negedge w_clk);
    req_valid = '1;
    req_data  = {N{8'hA5}};
    #1;
    n_cmp++;
    if (act_vec !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h, expected 0", act_vec);
    end
`ifdef FIFO_WR_ARB_STATS_EN
    n_cmp++;
    if ({beat_count, stall_count} !== 64'd0) begin
      n_err++;
      $display("FAIL reset_stats: got %0d/%0d, expected 0/0", beat_count, stall_count);
    end
`endif
    req_valid = '0;
    rst_w_n   = 1'b1;
  endtask

  task automatic test_two_requesters();
    int pulses;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      apply(4'b0101, '0, 1'b0);
      n_cmp++;
      if (act_vec !== exp_vec) begin
        n_err++;
        $display("FAIL two_req c%0d: got %h, expected %h", c, act_vec, exp_vec);
      end
      if (c < 11 && fifo_w_en === 1'b1) pulses++;
      if (c == 1 || c == 6 || c == 11) begin
        n_cmp++;
        if (grant !== ((c == 6) ? 4'b0100 : 4'b0001)) begin
          n_err++;
          $display("FAIL two_req_grant c%0d: got %b", c, grant);
        end
      end
      advance();
    end
    n_cmp++;
    if (pulses != 8) begin
      n_err++;
      $display("FAIL two_req_beats: got %0d, expected 8", pulses);
    end
    idle_cycles(2);
  endtask

  task automatic test_last();
    int pulses;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      apply((c < 3) ? 4'b0100 : 4'b0000, (c == 2) ? 4'b0100 : 4'b0000, 1'b0);
      n_cmp++;
      if (act_vec !== exp_vec) begin
        n_err++;
        $display("FAIL last c%0d: got %h, expected %h", c, act_vec, exp_vec);
      end
      if (fifo_w_en === 1'b1) pulses++;
      advance();
    end
    n_cmp++;
    if (pulses != 2 || grant !== 4'b0000) begin
      n_err++;
      $display("FAIL last_release: got %0d beats grant %b, expected 2 beats grant 0000", pulses, grant);
    end
    idle_cycles(1);
  endtask

  task automatic test_full_stall();
    int pulses;
    pulses = 0;
    for (int c = 0; c < 11; c++) begin
      apply((c < 10) ? 4'b0010 : 4'b0000, '0, (c >= 2 && c <= 6));
      n_cmp++;
      if (act_vec !== exp_vec) begin
        n_err++;
        $display("FAIL full c%0d: got %h, expected %h", c, act_vec, exp_vec);
      end
      if (c >= 2 && c <= 6) begin
        n_cmp++;
        if (fifo_w_en !== 1'b0 || req_ready !== 4'b0000 || grant !== 4'b0010) begin
          n_err++;
          $display("FAIL full_stall c%0d: got w_en %b ready %b grant %b, expected 0 0000 0010",
                   c, fifo_w_en, req_ready, grant);
        end
      end
      if (fifo_w_en === 1'b1) pulses++;
      advance();
    end
    n_cmp++;
    if (pulses != 4) begin
      n_err++;
      $display("FAIL full_beats: got %0d, expected 4", pulses);
    end
    idle_cycles(1);
  endtask

  task automatic test_drop_valid();
    logic [N-1:0] vseq [5];
    vseq = '{4'b0010, 4'b1010, 4'b1000, 4'b1000, 4'b1000};
    for (int c = 0; c < 5; c++) begin
      apply(vseq[c], '0, 1'b0);
      n_cmp++;
      if (act_vec !== exp_vec) begin
        n_err++;
        $display("FAIL drop c%0d: got %h, expected %h", c, act_vec, exp_vec);
      end
      if (c >= 3) begin
        n_cmp++;
        if (grant !== ((c == 3) ? 4'b0000 : 4'b1000)) begin
          n_err++;
          $display("FAIL drop_grant c%0d: got %b", c, grant);
        end
      end
      advance();
    end
    idle_cycles(2);
  endtask

  task automatic test_all_valid();
    int order [$];
    int exp_order [5];
    logic [N-1:0] prev;
    exp_order = '{0, 1, 2, 3, 0};
    prev = '0;
    for (int c = 0; c < 25; c++) begin
      apply('1, '0, 1'b0);
      n_cmp++;
      if (act_vec !== exp_vec) begin
        n_err++;
        $display("FAIL all c%0d: got %h, expected %h", c, act_vec, exp_vec);
      end
      if (prev == '0 && grant != '0) begin
        for (int i = 0; i < N; i++) if (grant[i]) order.push_back(i);
      end
      prev = grant;
      advance();
    end
    n_cmp++;
    if (order.size() != 5) begin
      n_err++;
      $display("FAIL all_order_len: got %0d grants, expected 5", order.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (order[i] != exp_order[i]) begin
          n_err++;
          $display("FAIL all_order[%0d]: got %0d, expected %0d", i, order[i], exp_order[i]);
        end
      end
    end
    idle_cycles(2);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      apply(N'($urandom), N'($urandom & $urandom), ($urandom_range(0, 3) == 0));
      n_cmp++;
      if (act_vec !== exp_vec) begin
        n_err++;
        $display("FAIL random c%0d: got %h, expected %h", c, act_vec, exp_vec);
      end
      advance();
    end
    apply('0, '0, 1'b0);
`ifdef FIFO_WR_ARB_STATS_EN
    n_cmp++;
    if (beat_count !== 32'(m_beat_tot) || stall_count !== 32'(m_stall_tot)) begin
      n_err++;
      $display("FAIL stats: got %0d/%0d, expected %0d/%0d",
               beat_count, stall_count, m_beat_tot, m_stall_tot);
    end
`endif
    advance();
    idle_cycles(2);
  endtask

  task automatic test_reset_mid_burst();
    for (int c = 0; c < 3; c++) begin
      apply('1, '0, 1'b0);
      n_cmp++;
      if (act_vec !== exp_vec) begin
        n_err++;
        $display("FAIL rstmid_pre c%0d: got %h, expected %h", c, act_vec, exp_vec);
      end
      advance();
    end
    #1;
    rst_w_n   = 1'b0;
    req_valid = '0;
    #1;
    n_cmp++;
    if ({grant, fifo_w_en, req_ready, busy} !== '0) begin
      n_err++;
      $display("FAIL rstmid_async: got grant %b w_en %b ready %b busy %b, expected all 0",
               grant, fifo_w_en, req_ready, busy);
    end
`ifdef FIFO_WR_ARB_STATS_EN
    n_cmp++;
    if ({beat_count, stall_count} !== 64'd0) begin
      n_err++;
      $display("FAIL rstmid_stats: got %0d/%0d, expected 0/0", beat_count, stall_count);
    end
`endif
    model_reset();
    @(negedge w_clk);
    rst_w_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      apply('1, '0, 1'b0);
      n_cmp++;
      if (act_vec !== exp_vec) begin
        n_err++;
        $display("FAIL rstmid_post c%0d: got %h, expected %h", c, act_vec, exp_vec);
      end
      if (c == 1) begin
        n_cmp++;
        if (grant !== 4'b0001) begin
          n_err++;
          $display("FAIL rstmid_first_grant: got %b, expected 0001", grant);
        end
      end
      advance();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_two_requesters();
    test_last();
    test_full_stall();
    test_drop_valid();
    test_all_valid();
    test_random();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
